// File: rtl/fifo_stream_reader.sv
// ============================================================================
// Module   : fifo_stream_reader
// Purpose  : Drains a first-word-fall-through FIFO into a valid/ready stream
//            through a 2-entry skid buffer, marking burst boundaries.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_stream_reader #(
    parameter int dataWidth = 8,
    parameter int burstLen  = 4
) (
    input  logic                 readClkIn,
    input  logic                 readRstIn,
    input  logic [dataWidth-1:0] fifoDataIn,
    input  logic                 fifoEmptyIn,
    output logic                 fifoReadEnOut,
    output logic [dataWidth-1:0] mDataOut,
    output logic                 mValidOut,
    input  logic                 mReadyIn,
    output logic                 mLastOut,
    output logic [15:0]          beatCountOut,
    input  logic                 flushIn
);

    localparam int                 c_IDX_W    = (burstLen > 1) ? $clog2(burstLen) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(burstLen - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    // Buffer occupancy doubles as the controller state.
    localparam logic [1:0] c_OCC_EMPTY = 2'd0;
    localparam logic [1:0] c_OCC_ONE   = 2'd1;
    localparam logic [1:0] c_OCC_FULL  = 2'd2;

    logic [1:0]           r_occ;
    logic [1:0]           w_occ_next;
    logic                 w_valid;
    logic                 w_pop;
    logic                 w_push;
    logic [dataWidth-1:0] r_head;
    logic [dataWidth-1:0] r_tail;
    logic [c_IDX_W-1:0]   r_beat_idx;
    logic [15:0]          r_beat_cnt;

    always_ff @(posedge readClkIn or negedge readRstIn) begin
        if (!readRstIn) begin
            r_occ <= c_OCC_EMPTY;
        end else begin
            r_occ <= w_occ_next;
        end
    end

    always_comb begin
        w_occ_next = r_occ;
        if (flushIn) begin
            w_occ_next = c_OCC_EMPTY;
        end else begin
            case (r_occ)
                c_OCC_EMPTY: begin
                    if (w_push) w_occ_next = c_OCC_ONE;
                end
                c_OCC_ONE: begin
                    if (w_push && !w_pop)      w_occ_next = c_OCC_FULL;
                    else if (!w_push && w_pop) w_occ_next = c_OCC_EMPTY;
                end
                c_OCC_FULL: begin
                    if (!w_push && w_pop) w_occ_next = c_OCC_ONE;
                end
                default: w_occ_next = c_OCC_EMPTY;
            endcase
        end
    end

    // Read enable is gated by reset so it is low while reset is held,
    // independent of the clock; mReadyIn only reaches it, no other output.
    always_comb begin
        w_valid = (r_occ != c_OCC_EMPTY);
        w_pop   = w_valid & mReadyIn & ~flushIn;
        w_push  = readRstIn & ~fifoEmptyIn & ~flushIn & ((r_occ != c_OCC_FULL) | w_pop);
    end

    always_ff @(posedge readClkIn or negedge readRstIn) begin
        if (!readRstIn) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case (r_occ)
                c_OCC_EMPTY: begin
                    if (w_push) r_head <= fifoDataIn;
                end
                c_OCC_ONE: begin
                    if (w_push && w_pop) r_head <= fifoDataIn;
                    else if (w_push)     r_tail <= fifoDataIn;
                end
                c_OCC_FULL: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        if (w_push) r_tail <= fifoDataIn;
                    end
                end
                default: begin
                    r_head <= r_head;
                end
            endcase
        end
    end

    always_ff @(posedge readClkIn or negedge readRstIn) begin
        if (!readRstIn) begin
            r_beat_idx <= '0;
            r_beat_cnt <= '0;
        end else if (flushIn) begin
            r_beat_idx <= '0;
        end else if (w_pop) begin
            r_beat_idx <= (r_beat_idx == c_LAST_IDX) ? '0 : (r_beat_idx + c_IDX_ONE);
            r_beat_cnt <= r_beat_cnt + 16'd1;
        end
    end

    assign fifoReadEnOut = w_push;
    assign mValidOut     = w_valid;
    assign mDataOut      = r_head;
    assign mLastOut      = w_valid & (r_beat_idx == c_LAST_IDX);
    assign beatCountOut  = r_beat_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
// ============================================================================
// Module   : tb_fifo_stream_reader
// Purpose  : Scenario bench for fifo_stream_reader with a FWFT source model
//            and an in-order scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] fifo_data;
    logic          fifo_empty;
    logic          rd_en;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic [15:0]   beat_cnt;
    logic          flush;

    int            checks    = 0;
    int            errors    = 0;
    int            pop_count = 0;
    int            rd_count  = 0;
    int            tb_idx    = 0;
    logic [15:0]   tb_cnt    = 16'd0;
    logic          s_en      = 1'b0;
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];

    fifo_stream_reader #(
        .dataWidth (DW),
        .burstLen  (BL)
    ) u_dut (
        .readClkIn     (clk),
        .readRstIn     (rst_n),
        .fifoDataIn    (fifo_data),
        .fifoEmptyIn   (fifo_empty),
        .fifoReadEnOut (rd_en),
        .mDataOut      (m_data),
        .mValidOut     (m_valid),
        .mReadyIn      (m_ready),
        .mLastOut      (m_last),
        .beatCountOut  (beat_cnt),
        .flushIn       (flush)
    );

    always #5 clk = ~clk;

    function automatic void refresh_src();
        fifo_empty = (src_q.size() == 0);
        fifo_data  = (src_q.size() == 0) ? '0 : src_q[0];
    endfunction

    // FWFT source: advances one word after each edge its read enable was high.
    always @(posedge clk) begin
        #1;
        if (s_en && src_q.size() > 0) void'(src_q.pop_front());
        refresh_src();
    end

    // Mid-cycle monitor: sees exactly what the next rising edge will act on.
    always @(negedge clk) begin
        logic [DW-1:0] exp_w;
        s_en = (rd_en === 1'b1);
        if (s_en) rd_count++;
        checks++;
        if (rd_en === 1'b1 && fifo_empty) begin
            errors++;
            $display("FAIL rd_while_empty: fifoReadEnOut=%b with fifoEmptyIn=1, required 0", rd_en);
        end
        checks++;
        if (beat_cnt !== tb_cnt) begin
            errors++;
            $display("FAIL beat_count: got %h expected %h", beat_cnt, tb_cnt);
        end
        if (rst_n === 1'b1 && flush === 1'b0 && m_valid === 1'b1 && m_ready === 1'b1) begin
            pop_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_order: unexpected beat %h, scoreboard empty", m_data);
            end else begin
                exp_w = exp_q.pop_front();
                if (m_data !== exp_w) begin
                    errors++;
                    $display("FAIL pop_order: got %h expected %h", m_data, exp_w);
                end
            end
            checks++;
            if (m_last !== (tb_idx == BL - 1)) begin
                errors++;
                $display("FAIL last_flag: got %b expected %b (beat %0d)", m_last, (tb_idx == BL - 1), tb_idx);
            end
            tb_idx = (tb_idx == BL - 1) ? 0 : tb_idx + 1;
            tb_cnt = tb_cnt + 16'd1;
        end else if (rst_n === 1'b1 && flush === 1'b1) begin
            tb_idx = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [DW-1:0] w);
        src_q.push_back(w);
        exp_q.push_back(w);
        refresh_src();
    endtask

    task automatic wait_drain(input int max_cycles, input string tag);
        int n = 0;
        while (!(src_q.size() == 0 && exp_q.size() == 0 && m_valid === 1'b0) && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= max_cycles) begin
            errors++;
            $display("FAIL %s_drain: timeout after %0d cycles, %0d words outstanding", tag, n, exp_q.size());
        end
    endtask

    task automatic test_reset();
        m_ready = 1'b0;
        flush   = 1'b0;
        refresh_src();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_last, rd_en} !== 3'b000 || m_data !== '0 || beat_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b last=%b rd=%b data=%h cnt=%h, required all 0",
                     m_valid, m_last, rd_en, m_data, beat_cnt);
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: valid=%b required 0", m_valid);
            end
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic test_empty();
        step();
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (rd_en !== 1'b0 || m_valid !== 1'b0) begin
                errors++;
                $display("FAIL empty_idle: rd=%b valid=%b required 0 0", rd_en, m_valid);
            end
        end
    endtask

    task automatic test_streaming();
        int n = 0;
        step();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) load(8'h11 + 8'(i));
        do begin
            @(negedge clk);
            n++;
        end while (m_valid !== 1'b1 && n < 10);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || m_data !== 8'h11 + 8'(i) || m_last !== (i == 3 || i == 7)) begin
                errors++;
                $display("FAIL stream_beat%0d: valid=%b data=%h last=%b, required 1 %h %b",
                         i, m_valid, m_data, m_last, 8'h11 + 8'(i), (i == 3 || i == 7));
            end
        end
        @(negedge clk);
        checks++;
        if (beat_cnt !== 16'd8) begin
            errors++;
            $display("FAIL stream_count: got %h expected 0008", beat_cnt);
        end
        wait_drain(20, "stream");
    endtask

    task automatic test_backpressure();
        int rd0;
        step();
        m_ready = 1'b0;
        rd0 = rd_count;
        for (int i = 0; i < 5; i++) load(8'h11 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== 8'h11) begin
                    errors++;
                    $display("FAIL bp_hold: valid=%b data=%h, required 1 11", m_valid, m_data);
                end
            end
        end
        checks++;
        if (rd_count - rd0 != 2) begin
            errors++;
            $display("FAIL bp_reads: got %0d read pulses expected 2", rd_count - rd0);
        end
        step();
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || m_data !== 8'h11 + 8'(i)) begin
                errors++;
                $display("FAIL bp_release%0d: valid=%b data=%h, required 1 %h", i, m_valid, m_data, 8'h11 + 8'(i));
            end
        end
        wait_drain(20, "bp");
    endtask

    task automatic test_single_insert();
        int rd0;
        int pop0;
        step();
        m_ready = 1'b1;
        rd0  = rd_count;
        pop0 = pop_count;
        load(8'h5A);
        repeat (8) @(negedge clk);
        checks++;
        if (rd_count - rd0 != 1 || pop_count - pop0 != 1) begin
            errors++;
            $display("FAIL single_insert: reads=%0d pops=%0d, required 1 1", rd_count - rd0, pop_count - pop0);
        end
    endtask

    task automatic test_flush();
        int          n;
        int          seen = 0;
        logic [15:0] saved;
        n = (2 - tb_idx + BL) % BL;
        step();
        m_ready = 1'b1;
        for (int k = 0; k < n; k++) load(8'h30 + 8'(k));
        wait_drain(n + 10, "pre_flush");
        step();
        m_ready = 1'b0;
        load(8'hA1);
        load(8'hA2);
        load(8'hA3);
        repeat (4) @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hA1 || rd_en !== 1'b0 || m_last !== 1'b0) begin
            errors++;
            $display("FAIL flush_setup: valid=%b data=%h rd=%b last=%b, required 1 a1 0 0",
                     m_valid, m_data, rd_en, m_last);
        end
        saved = tb_cnt;
        step();
        flush   = 1'b1;
        m_ready = 1'b1;
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        step();
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || beat_cnt !== saved) begin
            errors++;
            $display("FAIL flush_clear: valid=%b cnt=%h, required 0 %h", m_valid, beat_cnt, saved);
        end
        load(8'hB1);
        load(8'hB2);
        load(8'hB3);
        n = 0;
        while (seen < 4 && n < 20) begin
            @(negedge clk);
            n++;
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                seen++;
                checks++;
                if (m_last !== (seen == 4)) begin
                    errors++;
                    $display("FAIL flush_burst%0d: last=%b expected %b", seen, m_last, (seen == 4));
                end
            end
        end
        checks++;
        if (seen != 4) begin
            errors++;
            $display("FAIL flush_burst_beats: got %0d beats expected 4", seen);
        end
        wait_drain(20, "flush");
    endtask

    task automatic test_reset_mid();
        step();
        m_ready = 1'b0;
        load(8'hC1);
        repeat (3) @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hC1) begin
            errors++;
            $display("FAIL rstmid_setup: valid=%b data=%h, required 1 c1", m_valid, m_data);
        end
        step();
        load(8'hC2);
        load(8'hC3);
        #1 rst_n = 1'b0;
        tb_cnt = 16'd0;
        tb_idx = 0;
        void'(exp_q.pop_front());
        #1;
        checks++;
        if ({m_valid, m_last, rd_en} !== 3'b000 || m_data !== '0 || beat_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_async: valid=%b last=%b rd=%b data=%h cnt=%h, required all 0",
                     m_valid, m_last, rd_en, m_data, beat_cnt);
        end
        step();
        step();
        #1 rst_n = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rd_en !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_first_push: rd=%b required 1", rd_en);
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hC2) begin
            errors++;
            $display("FAIL rstmid_resume: valid=%b data=%h, required 1 c2", m_valid, m_data);
        end
        wait_drain(20, "rstmid");
    endtask

    task automatic test_counter_wrap();
        int n;
        n = 65535 - int'(tb_cnt);
        step();
        m_ready = 1'b1;
        for (int k = 0; k < n; k++) load(8'(k));
        wait_drain(n + 50, "wrap_fill");
        checks++;
        if (beat_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preset: got %h expected ffff", beat_cnt);
        end
        load(8'hEE);
        wait_drain(20, "wrap");
        checks++;
        if (beat_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_rollover: got %h expected 0000", beat_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_streaming();
        test_backpressure();
        test_single_insert();
        test_flush();
        test_reset_mid();
        test_counter_wrap();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d words never delivered, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
